// File: rtl/arith_pkg.sv
// Shared types and constants for the arithmetic status stage.
package arith_pkg;

  localparam int ARITH_WIDTH = 32;
  localparam int OVF_CNT_W   = 16;

  typedef struct packed {
    logic c;
    logic v;
    logic z;
    logic n;
  } arith_flags_t;

  localparam int FLAGS_W = $bits(arith_flags_t);

endpackage

// File: rtl/arith_skid_buf.sv
// Two-entry skid buffer (OUT + SKID) with a registered ready that equals "SKID empty".
module arith_skid_buf #(
  parameter int W = 36
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_data
);

  logic [W-1:0] out_q, out_d, skid_q, skid_d;
  logic         out_vld_q, out_vld_d, skid_vld_q, skid_vld_d;
  logic         rdy_q, rdy_d;
  logic         in_xfer, out_xfer;

  assign in_xfer  = in_valid & rdy_q;
  assign out_xfer = out_vld_q & out_ready;

  always_comb begin
    out_d      = out_q;
    out_vld_d  = out_vld_q;
    skid_d     = skid_q;
    skid_vld_d = skid_vld_q;
    if (out_xfer) begin
      // A full SKID implies rdy_q is low, so no input can arrive alongside the refill.
      if (skid_vld_q) begin
        out_d      = skid_q;
        skid_vld_d = 1'b0;
      end else if (in_xfer) begin
        out_d = in_data;
      end else begin
        out_vld_d = 1'b0;
      end
    end else if (in_xfer) begin
      if (!out_vld_q) begin
        out_d     = in_data;
        out_vld_d = 1'b1;
      end else begin
        skid_d     = in_data;
        skid_vld_d = 1'b1;
      end
    end
    rdy_d = ~skid_vld_d;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_q      <= '0;
      skid_q     <= '0;
      out_vld_q  <= 1'b0;
      skid_vld_q <= 1'b0;
      rdy_q      <= 1'b0;
    end else begin
      out_q      <= out_d;
      skid_q     <= skid_d;
      out_vld_q  <= out_vld_d;
      skid_vld_q <= skid_vld_d;
      rdy_q      <= rdy_d;
    end
  end

  assign in_ready  = rdy_q;
  assign out_valid = out_vld_q;
  assign out_data  = out_q;

endmodule

// File: rtl/arith_status_stage.sv
// Registers an arithmetic result with c/v/z/n flags behind a two-entry skid buffer.
// Optional sticky overflow flag and saturating overflow counter: define ARITH_STICKY_OVF_EN.
module arith_status_stage
  import arith_pkg::*;
#(
  parameter int WIDTH = ARITH_WIDTH
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [WIDTH-1:0]     in_g,
  input  logic                 in_cout,
  input  logic                 in_v,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [WIDTH-1:0]     out_g,
  output logic                 out_c,
  output logic                 out_v,
  output logic                 out_z,
  output logic                 out_n,
  input  logic                 clr_sticky,
  output logic                 sticky_v,
  output logic [OVF_CNT_W-1:0] ovf_count
);

  localparam int PW = WIDTH + FLAGS_W;

  function automatic arith_flags_t calc_flags(input logic [WIDTH-1:0] g,
                                              input logic cout, input logic v);
    arith_flags_t f;
    f.c = cout;
    f.v = v;
    f.z = (g == '0);
    f.n = g[WIDTH-1];
    return f;
  endfunction

  logic [PW-1:0] in_payload, out_payload;
  arith_flags_t  out_flags;

  assign in_payload = {in_g, calc_flags(in_g, in_cout, in_v)};

  arith_skid_buf #(.W(PW)) u_buf (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_payload),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_payload)
  );

  assign {out_g, out_flags} = out_payload;
  assign out_c = out_flags.c;
  assign out_v = out_flags.v;
  assign out_z = out_flags.z;
  assign out_n = out_flags.n;

`ifdef ARITH_STICKY_OVF_EN
  function automatic logic [OVF_CNT_W-1:0] sat_inc(input logic [OVF_CNT_W-1:0] x);
    return (x == '1) ? x : x + 1'b1;
  endfunction

  logic                 sticky_q, sticky_d, ovf_evt;
  logic [OVF_CNT_W-1:0] cnt_q, cnt_d;

  assign ovf_evt = in_valid & in_ready & in_v;

  // A clear coinciding with an overflow restarts the count at that overflow.
  always_comb begin
    sticky_d = sticky_q | ovf_evt;
    cnt_d    = ovf_evt ? sat_inc(cnt_q) : cnt_q;
    if (clr_sticky) begin
      sticky_d = ovf_evt;
      cnt_d    = ovf_evt ? OVF_CNT_W'(1) : '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sticky_q <= 1'b0;
      cnt_q    <= '0;
    end else begin
      sticky_q <= sticky_d;
      cnt_q    <= cnt_d;
    end
  end

  assign sticky_v  = sticky_q;
  assign ovf_count = cnt_q;
`else
  logic unused_clr;
  assign unused_clr = clr_sticky;
  assign sticky_v   = 1'b0;
  assign ovf_count  = '0;
`endif

endmodule

// File: tb/tb_arith_status_stage.sv
// Self-checking bench for arith_status_stage: directed vectors, corner sequences, random traffic.
module tb_arith_status_stage;

  logic        clk = 1'b0;
  logic        rst_n, in_valid, in_cout, in_v, out_ready, clr_sticky;
  logic [31:0] in_g;
  logic        in_ready, out_valid, out_c, out_v, out_z, out_n, sticky_v;
  logic [31:0] out_g;
  logic [15:0] ovf_count;

  arith_status_stage #(.WIDTH(32)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_g(in_g), .in_cout(in_cout), .in_v(in_v),
    .out_valid(out_valid), .out_ready(out_ready), .out_g(out_g),
    .out_c(out_c), .out_v(out_v), .out_z(out_z), .out_n(out_n),
    .clr_sticky(clr_sticky), .sticky_v(sticky_v), .ovf_count(ovf_count)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // Reference model: an in-order queue of accepted words with capacity two.
  typedef struct { logic [31:0] g; logic c; logic v; } word_t;
  word_t q[$];
  bit    armed;
  bit    sticky_m;
  int    cnt_m;

  typedef struct {
    logic [31:0] g; logic cout; logic v;
    logic ez; logic en; logic ec; logic ev;
  } vec_t;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_clear();
    q.delete();
    sticky_m = 1'b0;
    cnt_m    = 0;
    armed    = 1'b0;
  endtask

  // Entered and left at posedge+1; checks at negedge, then advances the model across the edge.
  task automatic step();
    bit    ir_e, ov_e, ixf, oxf, ovf;
    bit    exp_sv;
    int    exp_cnt;
    word_t w;
    @(negedge clk);
    ir_e = armed && (q.size() < 2);
    ov_e = (q.size() > 0);
    chk("in_ready", 64'(in_ready), 64'(ir_e));
    chk("out_valid", 64'(out_valid), 64'(ov_e));
    if (ov_e && out_valid) begin
      chk("out_g", 64'(out_g), 64'(q[0].g));
      chk("out_z", 64'(out_z), 64'(q[0].g == 32'd0));
      chk("out_n", 64'(out_n), 64'($signed(q[0].g) < 0));
      chk("out_c", 64'(out_c), 64'(q[0].c));
      chk("out_v", 64'(out_v), 64'(q[0].v));
    end
`ifdef ARITH_STICKY_OVF_EN
    exp_sv  = sticky_m;
    exp_cnt = cnt_m;
`else
    exp_sv  = 1'b0;
    exp_cnt = 0;
`endif
    chk("sticky_v", 64'(sticky_v), 64'(exp_sv));
    chk("ovf_count", 64'(ovf_count), 64'(exp_cnt));
    ixf = in_valid && ir_e;
    oxf = ov_e && out_ready;
    ovf = ixf && in_v;
    @(posedge clk);
    if (oxf) void'(q.pop_front());
    if (ixf) begin
      w.g = in_g; w.c = in_cout; w.v = in_v;
      q.push_back(w);
    end
    if (clr_sticky) begin
      sticky_m = ovf;
      cnt_m    = ovf ? 1 : 0;
    end else if (ovf) begin
      sticky_m = 1'b1;
      if (cnt_m < 65535) cnt_m++;
    end
    armed = 1'b1;
    #1;
  endtask

  task automatic set_in(input logic v, input logic [31:0] g, input logic c, input logic ov);
    in_valid = v; in_g = g; in_cout = c; in_v = ov;
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_out_valid"}, 64'(out_valid), 64'(0));
    chk({tag, "_in_ready"}, 64'(in_ready), 64'(0));
    chk({tag, "_out_g"}, 64'(out_g), 64'(0));
    chk({tag, "_flags"}, 64'({out_c, out_v, out_z, out_n}), 64'(0));
    chk({tag, "_sticky"}, 64'(sticky_v), 64'(0));
    chk({tag, "_count"}, 64'(ovf_count), 64'(0));
  endtask

  // Assert reset mid-cycle, check the asynchronous effect, release, expect ready after one edge.
  task automatic do_reset(input string tag);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk_reset_outputs(tag);
    model_clear();
    @(posedge clk); #1;
    chk({tag, "_held"}, 64'(out_valid), 64'(0));
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk({tag, "_ready_before_edge"}, 64'(in_ready), 64'(0));
    @(posedge clk); #1;
    chk({tag, "_ready_after_edge"}, 64'(in_ready), 64'(1));
    armed = 1'b1;
  endtask

  initial begin
    vec_t vecs[6];
    bit   dropped;

    vecs[0] = '{32'h0000_0000, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
    vecs[1] = '{32'h8000_0000, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
    vecs[2] = '{32'h0000_0005, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[3] = '{32'hFFFF_FFFF, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
    vecs[4] = '{32'h7FFF_FFFF, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
    vecs[5] = '{32'h0000_0001, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1};

    rst_n = 1'b1; clr_sticky = 1'b0; out_ready = 1'b0;
    set_in(1'b0, 32'd0, 1'b0, 1'b0);
    model_clear();
    #2;
    do_reset("reset");

    // Single words with fixed flag expectations, one-cycle latency.
    for (int i = 0; i < 6; i++) begin
      set_in(1'b1, vecs[i].g, vecs[i].cout, vecs[i].v);
      out_ready = 1'b1;
      step();
      set_in(1'b0, 32'd0, 1'b0, 1'b0);
      chk($sformatf("vec%0d_valid", i), 64'(out_valid), 64'(1));
      chk($sformatf("vec%0d_g", i), 64'(out_g), 64'(vecs[i].g));
      chk($sformatf("vec%0d_zncv", i), 64'({out_z, out_n, out_c, out_v}),
          64'({vecs[i].ez, vecs[i].en, vecs[i].ec, vecs[i].ev}));
      step();
    end

    // Streaming: one word per cycle, ready never drops.
    dropped = 1'b0;
    out_ready = 1'b1;
    for (int i = 1; i <= 10; i++) begin
      set_in(1'b1, 32'(i), 1'b0, 1'b0);
      if (!in_ready) dropped = 1'b1;
      step();
      chk($sformatf("stream_out%0d", i), 64'(out_g), 64'(i));
    end
    chk("stream_ready_held", 64'(dropped), 64'(0));
    set_in(1'b0, 32'd0, 1'b0, 1'b0);
    step();

    // Backpressure: fill OUT and SKID, then drain in order.
    out_ready = 1'b0;
    set_in(1'b1, 32'h8000_0000, 1'b0, 1'b0);
    step();
    set_in(1'b1, 32'h0000_0005, 1'b0, 1'b0);
    step();
    set_in(1'b0, 32'd0, 1'b0, 1'b0);
    chk("bp_ready_low", 64'(in_ready), 64'(0));
    step();
    chk("bp_hold_g", 64'(out_g), 64'(32'h8000_0000));
    chk("bp_hold_n", 64'(out_n), 64'(1));
    out_ready = 1'b1;
    step();
    chk("bp_second_g", 64'(out_g), 64'(5));
    chk("bp_second_n", 64'(out_n), 64'(0));
    chk("bp_ready_back", 64'(in_ready), 64'(1));
    step();
    step();

    // Overflow bookkeeping.
    clr_sticky = 1'b1;
    step();
    clr_sticky = 1'b0;
    for (int i = 0; i < 3; i++) begin
      set_in(1'b1, 32'(100 + i), 1'b0, 1'b1);
      step();
    end
    set_in(1'b0, 32'd0, 1'b0, 1'b0);
`ifdef ARITH_STICKY_OVF_EN
    chk("sticky_after3", 64'(sticky_v), 64'(1));
    chk("count_after3", 64'(ovf_count), 64'(3));
    set_in(1'b1, 32'd200, 1'b0, 1'b1);
    clr_sticky = 1'b1;
    step();
    clr_sticky = 1'b0;
    set_in(1'b0, 32'd0, 1'b0, 1'b0);
    chk("sticky_clr_coincident", 64'(sticky_v), 64'(1));
    chk("count_clr_coincident", 64'(ovf_count), 64'(1));
`else
    chk("sticky_disabled", 64'(sticky_v), 64'(0));
    chk("count_disabled", 64'(ovf_count), 64'(0));
    clr_sticky = 1'b1;
    set_in(1'b1, 32'd200, 1'b0, 1'b1);
    step();
    clr_sticky = 1'b0;
    set_in(1'b0, 32'd0, 1'b0, 1'b0);
    chk("count_disabled_clr", 64'(ovf_count), 64'(0));
`endif
    step();
    step();

    // Random traffic against the queue model.
    for (int i = 0; i < 400; i++) begin
      logic [31:0] g;
      case ($urandom_range(0, 3))
        0:       g = 32'd0;
        1:       g = 32'h8000_0000 | $urandom;
        default: g = $urandom;
      endcase
      set_in(1'($urandom_range(0, 1)), g, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      out_ready  = ($urandom_range(0, 3) != 0);
      clr_sticky = ($urandom_range(0, 15) == 0);
      step();
    end
    clr_sticky = 1'b0;
    set_in(1'b0, 32'd0, 1'b0, 1'b0);

    // Reset with both entries full: no stale word afterwards.
    out_ready = 1'b0;
    step(); step(); step();
    set_in(1'b1, 32'hDEAD_0001, 1'b1, 1'b1);
    step();
    set_in(1'b1, 32'hDEAD_0002, 1'b0, 1'b1);
    step();
    set_in(1'b0, 32'd0, 1'b0, 1'b0);
    chk("mid_full_ready", 64'(in_ready), 64'(0));
    do_reset("midreset");
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) step();
    chk("mid_no_stale", 64'(out_valid), 64'(0));

`ifdef ARITH_STICKY_OVF_EN
    // Saturation: drive the counter to FFFE, then three more overflows.
    clr_sticky = 1'b1;
    step();
    clr_sticky = 1'b0;
    out_ready = 1'b1;
    set_in(1'b1, 32'd7, 1'b0, 1'b1);
    while (cnt_m < 16'hFFFE) step();
    chk("sat_preload", 64'(ovf_count), 64'(16'hFFFE));
    for (int i = 0; i < 3; i++) step();
    set_in(1'b0, 32'd0, 1'b0, 1'b0);
    chk("sat_count", 64'(ovf_count), 64'(16'hFFFF));
    step();
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/arith_status_stage.md
ARITH_STATUS_STAGE -- requirements
Module: arith_status_stage

Interface
REQ-001 Parameter: WIDTH, 32, operand/result width; matches the upstream arithmetic circuit.
REQ-002 Port: clk  input  1  single clock; all state updates on rising edge.
REQ-003 Port: rst_n  input  1  reset, asynchronous assert, active-low.
REQ-004 Port: in_valid  input  1  upstream result G/Cout/V is valid this cycle.
REQ-005 Port: in_ready  output  1  stage can accept a result this cycle.
REQ-006 Port: in_g  input  WIDTH  sum/difference G from the arithmetic circuit.
REQ-007 Port: in_cout  input  1  carry-out from the arithmetic circuit.
REQ-008 Port: in_v  input  1  signed overflow from the arithmetic circuit.
REQ-009 Port: out_valid  output  1  registered result available downstream.
REQ-010 Port: out_ready  input  1  downstream accepts the result this cycle.
REQ-011 Port: out_g  output  WIDTH  registered G.
REQ-012 Port: out_c, out_v, out_z, out_n  output  1 each  carry, overflow, zero, negative flags.
REQ-013 Port: clr_sticky  input  1  clear sticky overflow state.
REQ-014 Port: sticky_v  output  1  an overflow has been accepted since the last clear.
REQ-015 Port: ovf_count  output  16  number of overflowing results accepted, saturating.

Function
REQ-016 An input transfer SHALL occur when in_valid and in_ready are both high; an output transfer when out_valid and out_ready are both high.
REQ-017 The stage SHALL hold two entries: output register (OUT) and skid register (SKID).
REQ-018 in_ready SHALL be a registered signal equal to "SKID empty".
REQ-019 On an input transfer with OUT empty, or with OUT full and an output transfer in the same cycle, the word SHALL load OUT; latency from in to out_valid is exactly 1 cycle.
REQ-020 On an input transfer with OUT full and no output transfer, the word SHALL load SKID; in_ready SHALL drop the next cycle.
REQ-021 On an output transfer with SKID full, SKID SHALL move to OUT and in_ready SHALL rise the next cycle.
REQ-022 Words SHALL leave in acceptance order; no word is dropped or duplicated.
REQ-023 Flags SHALL be computed at acceptance: z = (in_g == 0), n = in_g[WIDTH-1], c = in_cout, v = in_v.
REQ-024 out_g and flags SHALL hold stable while out_valid is high and out_ready is low.
REQ-025 sticky_v SHALL set on any input transfer carrying in_v = 1.
REQ-026 ovf_count SHALL increment by 1 on each input transfer with in_v = 1 and saturate at 16'hFFFF.
REQ-027 clr_sticky SHALL clear sticky_v to 0 and ovf_count to 0; when it coincides with an overflowing input transfer, sticky_v SHALL be 1 and ovf_count SHALL be 1 (the event is not lost).

Reset
REQ-028 rst_n low SHALL immediately force out_valid = 0, OUT and SKID empty, out_g = 0, all flags = 0, sticky_v = 0, ovf_count = 0, in_ready = 0.
REQ-029 in_ready SHALL go to 1 on the first clock edge after rst_n deasserts; reset mid-transfer discards both buffered words.

Configuration
REQ-030 Macro ARITH_STICKY_OVF_EN: when defined, REQ-025 to REQ-027 apply.
REQ-031 Without ARITH_STICKY_OVF_EN, sticky_v and ovf_count SHALL be constant 0, clr_sticky SHALL be ignored, and no counter logic SHALL be synthesized; the port list SHALL be unchanged.

Structure
REQ-032 Shared package arith_pkg SHALL hold the default WIDTH, the 16-bit counter width constant, and the flag record type {c, v, z, n}.
REQ-033 The two-entry buffer SHALL be a sub-module arith_skid_buf parameterized by payload width; flag and overflow logic stays in the top module.

Verification
REQ-034 Single word: in_g = 0, in_cout = 1, in_v = 0, out_ready = 1 -> next cycle out_valid = 1, out_z = 1, out_c = 1, out_n = 0.
REQ-035 Backpressure: out_ready = 0; send 32'h8000_0000 then 32'h0000_0005 -> in_ready drops; release out_ready -> outputs in order, first with out_n = 1, then in_ready rises.
REQ-036 Streaming: in_valid and out_ready high for 10 cycles with G = 1..10 -> one output per cycle, values 1..10, in_ready never drops.
REQ-037 Sticky (macro on): 3 transfers with in_v = 1 -> sticky_v = 1, ovf_count = 3; clr_sticky coincident with a 4th -> ovf_count = 1, sticky_v = 1.
REQ-038 Saturation (macro on): preload ovf_count to 16'hFFFE and send 3 overflowing words -> ovf_count = 16'hFFFF.
REQ-039 Reset mid-operation: with both entries full, assert rst_n low -> out_valid = 0 immediately; after release, in_ready = 1 after one edge and no stale word appears.
